serial_addsub_c1: RTL and testbench

- Bit-serial ones'-complement adder/subtractor. It sits directly downstream of the 4-bit ones'-complement stage.
- It consumes operand B together with the cpl control: B is inverted when cpl=1, then added to A LSB-first, one bit per clock.
- The end-around carry is applied in a final correction cycle.
- A start/done handshake lets a controller sequence operations.

---
 rtl/serial_addsub_c1.sv | 75 +++++++
 tb/tb_serial_addsub_c1.sv | 121 ++++++++++++
 2 files changed

// File: rtl/serial_addsub_c1.sv
// serial_addsub_c1: bit-serial ones'-complement add/subtract, LSB first, end-around carry in a final cycle.
// Optional SERIAL_ADDSUB_C1_NEGZERO_NORM_EN rewrites a negative-zero result as canonical zero.
module serial_addsub_c1 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cpl,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, EAC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, eac_sum, eac_val;
  logic [CW-1:0] cnt;
  logic cpl_r, carry, bb, s, last, busy_nx, done_nx;
  assign last = cnt == CW'(WIDTH - 1);
  assign bb = b_sh[0] ^ cpl_r;
  assign s = a_sh[0] ^ bb ^ carry;
  assign eac_sum = result + WIDTH'(carry);
`ifdef SERIAL_ADDSUB_C1_NEGZERO_NORM_EN
  assign eac_val = &eac_sum ? '0 : eac_sum;
`else
  assign eac_val = eac_sum;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (last ? EAC : SHIFT) :
               state == EAC   ? DONE : IDLE;
  end
  always_comb begin
    busy_nx = state_nx != IDLE;
    done_nx = state_nx == DONE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      cpl_r  <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
      if (state == IDLE && start) begin
        a_sh  <= a;
        b_sh  <= b;
        cpl_r <= cpl;
        carry <= 1'b0;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        carry  <= (a_sh[0] & bb) | (a_sh[0] & carry) | (bb & carry);
        result <= {s, result[WIDTH-1:1]};
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        cnt    <= cnt + CW'(1);
      end else if (state == EAC) begin
        cout   <= carry;
        result <= eac_val;
      end
    end
endmodule

// File: tb/tb_serial_addsub_c1.sv
// tb_serial_addsub_c1: scoreboard bench; driver pushes arithmetic-model expectations, monitor pops on done.
module tb_serial_addsub_c1;
  localparam int W = 4;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, cpl = 1'b0;
  logic [W-1:0] a = '0, b = '0, result;
  logic cout, busy, done;
  int checks = 0, failures = 0, cyc = 0;
  logic [W:0] exp_q[$];
  int acc_q[$];

  serial_addsub_c1 #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .cpl(cpl),
    .result(result), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [W:0] model(input logic [W-1:0] x, y, input logic c);
    logic [W:0] s;
    logic [W-1:0] r;
    s = {1'b0, x} + {1'b0, c ? ~y : y};
    r = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
`ifdef SERIAL_ADDSUB_C1_NEGZERO_NORM_EN
    if (&r) r = '0;
`endif
    return {s[W], r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] x, y, input logic c, input bit junk,
                       input logic [W-1:0] jx, jy, input logic jc);
    wait_idle();
    a = x; b = y; cpl = c; start = 1'b1;
    exp_q.push_back(model(x, y, c));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    if (junk) begin
      a = jx; b = jy; cpl = jc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    a = W'($urandom); b = W'($urandom); cpl = 1'($urandom);
  endtask

  always @(negedge clk) begin
    if (reset_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [W:0] e;
        int acc;
        e = exp_q.pop_front();
        acc = acc_q.pop_front();
        chk("result", 32'(result), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
        chk("latency", 32'(cyc - acc), 32'(W + 1));
        chk("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  initial begin
    #12;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'b0101, 4'b0011, 1'b0, 1'b0, '0, '0, 1'b0);
    issue(4'b0101, 4'b0011, 1'b1, 1'b0, '0, '0, 1'b0);
    issue(4'b0011, 4'b0101, 1'b1, 1'b0, '0, '0, 1'b0);
    issue(4'b0101, 4'b0101, 1'b1, 1'b0, '0, '0, 1'b0);
    issue(4'b1111, 4'b1111, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b0);
    issue(4'b0000, 4'b0000, 1'b1, 1'b0, '0, '0, 1'b0);
    // abort two edges into SHIFT; no expectation is queued for this one
    wait_idle();
    a = 4'b1011; b = 4'b0110; cpl = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(4'b0010, 4'b0001, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 150; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            W'($urandom), W'($urandom), 1'($urandom));
    wait_idle();
    repeat (W + 4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
